// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches host-loaded 16-bit instruction words one per cycle
// and forwards them to the decoder. WAIT and HALT are consumed here and
// appear on the instruction bus as NOP (16'h0000).
module instr_sequencer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  input  logic              stall,
  output logic [15:0]       instruction,
  output logic [ADDR_W:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  localparam logic [2:0]    OP_WAIT = 3'b110;
  localparam logic [2:0]    OP_HALT = 3'b111;
  localparam logic [ADDR_W:0] PC_END = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [12:0]       wait_cnt, wait_cnt_nxt;
  logic [15:0]       instr_nxt;
  logic [ADDR_W:0]   pc_nxt;
  logic              error_nxt;
  logic              do_fetch;
  logic [15:0]       fetch_word;
  logic [15:0]       mem [DEPTH];

  assign busy = (state == S_RUN) || (state == S_WAIT);
  assign done = (state == S_DONE);

  // Start always fetches address 0; in RUN the fetch address is pc. The
  // combinational read gives read-before-write against a same-edge host write.
  assign fetch_word = (state == S_RUN) ? mem[pc[ADDR_W-1:0]] : mem[0];

  // Host program writes; memory has no reset so programs survive across runs.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instruction <= '0;
      pc          <= '0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      instruction <= instr_nxt;
      pc          <= pc_nxt;
      error       <= error_nxt;
    end
  end

  // Next-state logic; the instruction bus defaults to NOP every cycle so a
  // forwarded word is never presented twice.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    instr_nxt    = '0;
    pc_nxt       = pc;
    error_nxt    = error;
    do_fetch     = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          do_fetch  = 1'b1;
          pc_nxt    = (ADDR_W+1)'(1);
          error_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (pc == PC_END) begin
            // Ran past the last word without a HALT.
            state_nxt = S_DONE;
            error_nxt = 1'b1;
          end else begin
            do_fetch = 1'b1;
            pc_nxt   = pc + (ADDR_W+1)'(1);
          end
        end
      end
      S_WAIT: begin
        // Counts regardless of stall; leaves on the edge where it reads 1.
        wait_cnt_nxt = wait_cnt - 13'd1;
        if (wait_cnt == 13'd1) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (do_fetch) begin
      case (fetch_word[15:13])
        OP_WAIT: begin
          wait_cnt_nxt = fetch_word[12:0];
          state_nxt    = (fetch_word[12:0] == 13'd0) ? S_RUN : S_WAIT;
        end
        OP_HALT: state_nxt = S_DONE;
        default: begin
          instr_nxt = fetch_word;
          state_nxt = S_RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction issuer for the systolic-array datapath. Holds a small host-loaded program memory of 16-bit instruction words. After `start`, it fetches one word per cycle and drives the `instruction` bus into the instruction decoder, which turns each word into load_weight/load_input/valid/store pulses and base_address updates. The sequencer consumes two local opcodes, WAIT and HALT, and never forwards them; it provides stall, done and error status to the host.

## Interface
- DEPTH, 64: program memory words; power of two, at least 2.
- ADDR_W, 6: $clog2(DEPTH).
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- prog_we  in  1  host program-memory write strobe.
- prog_addr  in  ADDR_W  host write address.
- prog_data  in  16  host write data (instruction word).
- start  in  1  begin execution at address 0; level-sampled.
- stall  in  1  datapath backpressure; holds fetch.
- instruction  out  16  registered instruction to the decoder.
- pc  out  ADDR_W+1  index of the next word to fetch.
- busy  out  1  high in RUN and WAIT.
- done  out  1  high in DONE.
- error  out  1  sticky flag: program ran off the end of memory without HALT.

## Operation
- Opcode field is [15:13]:
  - 000 NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUTS, 100 VALID, 101 STORE: forwarded verbatim.
  - 110 WAIT: [12:0] = n.
  - 111 HALT.
- NOP on `instruction` is 16'h0000.
- States: IDLE, RUN, WAIT, DONE.
- IDLE / DONE:
  - `instruction` = 0.
  - prog_we writes mem[prog_addr].
  - start=1 performs the fetch of mem[0] (see fetch rule), sets pc=1, clears error, and moves to RUN.
  - DONE persists until start or reset.
- RUN, stall=1: `instruction` <= 0 and pc is held.
- RUN, stall=0: fetch word w = mem[pc], then pc <= pc+1.
- Fetch rule, applied to every fetch:
  - opcode 000–101: `instruction` <= w.
  - WAIT: `instruction` <= 0, wait counter <= n. If n=0, stay in RUN; otherwise go to WAIT.
  - HALT: `instruction` <= 0, go to DONE.
- WAIT state:
  - `instruction` = 0.
  - The counter decrements every cycle, ignoring stall.
  - When the counter equals 1, return to RUN on the next edge.
  - A WAIT word therefore occupies exactly n+1 NOP cycles.
- Run-off: if pc == DEPTH when a fetch would occur (stall=0 in RUN), go to DONE with `instruction` <= 0, and set error=1.
- prog_we is ignored while busy.
- Program memory is not cleared by reset; its contents persist across runs.

## Timing
- Reset value of every output:
  - instruction = 0, pc = 0, busy = 0, done = 0, error = 0.
  - State returns to IDLE; the wait counter is cleared.
- Reset wins over all other inputs. Reset mid-RUN or mid-WAIT returns to IDLE on the next edge, with `instruction` = 0 from that edge.
- Fetch latency: start sampled at edge E places mem[0] (or NOP, for WAIT/HALT) on `instruction` from E until E+1. Each later non-stalled edge advances one word.
- Throughput is one instruction per cycle with no bubbles, except for stall, WAIT and HALT.
- Stall: on an edge sampling stall=1, `instruction` <= 0. Each forwarded word is therefore presented for exactly one cycle, so the decoder never sees a duplicated pulse.
- busy/done reflect the state register: busy rises the cycle after start is sampled, and done rises the cycle after HALT is fetched.
- prog_we and start in the same IDLE cycle: the write commits at that edge, but the fetch of mem[0] uses the pre-write contents (read-before-write).
- start while busy is ignored.
- HALT at address DEPTH-1 is a normal HALT: error stays 0.

## Test plan
- **Basic issue.** Load [0]=16'h2005, [1]=16'h4000, [2]=16'h6000, [3]=16'h8000, [4]=16'hA000, [5]=16'hE000, then pulse start.
  - instruction shows 2005, 4000, 6000, 8000, A000 on 5 consecutive cycles, then 0.
  - done=1 and pc=6.
- **WAIT.** Load [0]=16'h8000, [1]=16'hC003, [2]=16'hA000, [3]=16'hE000.
  - Sequence is 8000, then 4 cycles of 0, then A000.
  - busy stays 1 throughout.
  - Repeat with 16'hC000: exactly 1 NOP cycle between 8000 and A000.
- **Stall.** Same program as the basic test; assert stall for 2 cycles after 4000 appears.
  - 4000 is shown for 1 cycle, then 2 cycles of 0, then 6000.
  - pc is held at 2 during the stall.
- **Run-off.** DEPTH=4 with no HALT in the program.
  - After 4 words, done=1 and error=1.
  - A fresh start clears error.
- **Reset mid-run.** Assert reset during the WAIT of the WAIT program.
  - Next cycle: busy=0, instruction=0, pc=0.
  - Memory is retained: start replays 8000 first.
- **Host-write gating.** prog_we while busy does not alter memory (verified by the rerun). prog_we together with start in IDLE fetches the old mem[0].
